// File: rtl/seven_seg_display_ctrl_pkg.sv
// seven_seg_pkg: shared segment width, hex glyph table and polarity helper
//   hex_to_seg   : 4-bit nibble -> active-high glyph (bit0 = a .. bit6 = g)
//   seg_polarity : inverts a glyph for active-low boards
package seven_seg_pkg;
    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
        return GLYPHS[nib];
    endfunction
    function automatic logic [SEG_W-1:0] seg_polarity(input logic [SEG_W-1:0] seg, input logic active_low);
        return active_low ? ~seg : seg;
    endfunction
endpackage

// File: rtl/seven_seg_display_ctrl_tick_div.sv
// seg_tick_div: free-running 0..DIV-1 counter with a wrap pulse
//   clk, rst       : clock, synchronous active-high reset
//   tick_o         : high in the last cycle of each period (counter = DIV-1)
//   cnt_is_zero_o  : high in the first cycle of each period
module seg_tick_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o,
    output logic cnt_is_zero_o
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    if (DIV < 2) begin : g_bad_div
        $error("seg_tick_div: DIV must be >= 2");
    end
    logic [W-1:0] cnt_q, cnt_d;
    assign tick_o        = cnt_q == W'(DIV - 1);
    assign cnt_is_zero_o = cnt_q == '0;
    assign cnt_d         = tick_o ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/seven_seg_display_ctrl.sv
// seven_seg_display_ctrl: N-digit hex display with shadow regs, blink, LZB and optional scan
//   clk, rst        : clock, synchronous active-high reset
//   load_i          : captures value_i / digit_en_i / blink_mask_i / lzb_en_i
//   value_i         : nibble i drives digit i (digit 0 least significant)
//   digit_en_i      : per-digit enable
//   blink_mask_i    : per-digit blink enable
//   lzb_en_i        : leading-zero blanking enable
//   seg_out_o       : static segments, digit i at [7i+6:7i] (MUX_MODE=0)
//   scan_seg_o      : shared segment bus (MUX_MODE=1)
//   scan_an_o       : one-hot digit select (MUX_MODE=1)
module seven_seg_display_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int SCAN_DIV   = 50_000,
    parameter int MUX_MODE   = 0,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_i,
    input  logic [4*NUM_DIGITS-1:0]     value_i,
    input  logic [NUM_DIGITS-1:0]       digit_en_i,
    input  logic [NUM_DIGITS-1:0]       blink_mask_i,
    input  logic                        lzb_en_i,
    output logic [SEG_W*NUM_DIGITS-1:0] seg_out_o,
    output logic [SEG_W-1:0]            scan_seg_o,
    output logic [NUM_DIGITS-1:0]       scan_an_o
);
    localparam logic [SEG_W-1:0]      BLANK  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ACTIVE_LOW != 0}};
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_nd
        $error("seven_seg_display_ctrl: NUM_DIGITS must be 1..8");
    end
    if (BLINK_DIV < 2 || SCAN_DIV < 2) begin : g_bad_div
        $error("seven_seg_display_ctrl: BLINK_DIV and SCAN_DIV must be >= 2");
    end
    if (MUX_MODE < 0 || MUX_MODE > 1 || ACTIVE_LOW < 0 || ACTIVE_LOW > 1) begin : g_bad_mode
        $error("seven_seg_display_ctrl: MUX_MODE and ACTIVE_LOW must be 0 or 1");
    end
    logic [4*NUM_DIGITS-1:0]     val_q;
    logic [NUM_DIGITS-1:0]       en_q, bm_q;
    logic                        lzb_q, phase_q;
    logic [IW-1:0]               idx_q, idx_d;
    logic                        blink_tick, scan_tick, scan_zero, unused_blink_zero;
    logic                        hi_nz;
    logic [SEG_W-1:0]            glyph [NUM_DIGITS];
    logic [SEG_W*NUM_DIGITS-1:0] seg_q, seg_d;
    logic [SEG_W-1:0]            scan_seg_q, scan_seg_d;
    logic [NUM_DIGITS-1:0]       scan_an_q, scan_an_d;
    seg_tick_div #(.DIV(BLINK_DIV)) u_blink (
        .clk(clk), .rst(rst), .tick_o(blink_tick), .cnt_is_zero_o(unused_blink_zero)
    );
    seg_tick_div #(.DIV(SCAN_DIV)) u_scan (
        .clk(clk), .rst(rst), .tick_o(scan_tick), .cnt_is_zero_o(scan_zero)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q   <= '0;
            en_q    <= '0;
            bm_q    <= '0;
            lzb_q   <= 1'b0;
            phase_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            if (load_i) begin
                val_q <= value_i;
                en_q  <= digit_en_i;
                bm_q  <= blink_mask_i;
                lzb_q <= lzb_en_i;
            end
            phase_q <= phase_q ^ blink_tick;
            idx_q   <= idx_d;
        end
    end
    assign idx_d = !scan_tick ? idx_q : (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    // Walk from the top digit down so hi_nz means "some nibble at or above i is non-zero".
    always_comb begin
        hi_nz = 1'b0;
        seg_d = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            hi_nz    = hi_nz | (|val_q[4*i +: 4]);
            glyph[i] = (!en_q[i] || (bm_q[i] && phase_q) || (lzb_q && i > 0 && !hi_nz))
                     ? BLANK : seg_polarity(hex_to_seg(val_q[4*i +: 4]), ACTIVE_LOW != 0);
            seg_d[SEG_W*i +: SEG_W] = (MUX_MODE != 0) ? BLANK : glyph[i];
        end
    end
    // The first cycle of every slot is dark so the previous digit cannot ghost.
    assign scan_seg_d = (MUX_MODE == 0 || scan_zero) ? BLANK : glyph[idx_q];
    assign scan_an_d  = (MUX_MODE == 0 || scan_zero) ? AN_OFF : AN_OFF ^ (NUM_DIGITS'(1) << idx_q);
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q      <= {NUM_DIGITS{BLANK}};
            scan_seg_q <= BLANK;
            scan_an_q  <= AN_OFF;
        end else begin
            seg_q      <= seg_d;
            scan_seg_q <= scan_seg_d;
            scan_an_q  <= scan_an_d;
        end
    end
    assign seg_out_o  = seg_q;
    assign scan_seg_o = scan_seg_q;
    assign scan_an_o  = scan_an_q;
endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// tb_seven_seg_display_ctrl: scoreboard bench over static, scanned active-low and scanned active-high builds
module tb_seven_seg_display_ctrl;
    localparam int ND = 4;
    localparam int BD = 4;
    localparam int SD = 3;
    localparam logic [6:0] GLY [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    typedef struct {
        logic [27:0] seg0; logic [6:0] ss0; logic [3:0] sa0;
        logic [27:0] seg1; logic [6:0] ss1; logic [3:0] sa1;
        logic [27:0] seg2; logic [6:0] ss2; logic [3:0] sa2;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  digit_en = '0, blink_mask = '0;
    logic        lzb_en = 1'b0;
    logic [27:0] so0, so1, so2;
    logic [6:0]  ss0, ss1, ss2;
    logic [3:0]  sa0, sa1, sa2;
    exp_t        q [$];
    int          n_cmp = 0, n_bad = 0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_en = '0, m_bm = '0;
    logic        m_lzb = 1'b0;
    int          k = 0;
    bit          started = 0;
    always #5 clk = ~clk;
    seven_seg_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD), .SCAN_DIV(SD), .MUX_MODE(0), .ACTIVE_LOW(1)) u0 (
        .clk(clk), .rst(rst), .load_i(load), .value_i(value), .digit_en_i(digit_en),
        .blink_mask_i(blink_mask), .lzb_en_i(lzb_en), .seg_out_o(so0), .scan_seg_o(ss0), .scan_an_o(sa0));
    seven_seg_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD), .SCAN_DIV(SD), .MUX_MODE(1), .ACTIVE_LOW(1)) u1 (
        .clk(clk), .rst(rst), .load_i(load), .value_i(value), .digit_en_i(digit_en),
        .blink_mask_i(blink_mask), .lzb_en_i(lzb_en), .seg_out_o(so1), .scan_seg_o(ss1), .scan_an_o(sa1));
    seven_seg_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD), .SCAN_DIV(SD), .MUX_MODE(1), .ACTIVE_LOW(0)) u2 (
        .clk(clk), .rst(rst), .load_i(load), .value_i(value), .digit_en_i(digit_en),
        .blink_mask_i(blink_mask), .lzb_en_i(lzb_en), .seg_out_o(so2), .scan_seg_o(ss2), .scan_an_o(sa2));
    // Glyph digit i shows after edge kk, given the shadow contents held before that edge.
    function automatic logic [6:0] digit_glyph(int i, bit al, int kk);
        bit          phase = ((kk - 1) / BD) % 2 == 1;
        bit          blank = !m_en[i] || (m_bm[i] && phase) || (m_lzb && i > 0 && (m_val >> (4 * i)) == 16'h0);
        logic [6:0]  g = blank ? 7'h00 : GLY[m_val[4*i +: 4]];
        return al ? ~g : g;
    endfunction
    initial forever begin
        exp_t e;
        int   p, idx;
        @(posedge clk);
        if (rst) begin
            e = '{28'hFFFFFFF, 7'h7F, 4'hF, 28'hFFFFFFF, 7'h7F, 4'hF, 28'h0, 7'h00, 4'h0};
            m_val = '0; m_en = '0; m_bm = '0; m_lzb = 1'b0;
            k = 0;
            started = 1;
            q.push_back(e);
        end else if (started) begin
            k++;
            p   = (k - 1) % SD;
            idx = ((k - 1) / SD) % ND;
            for (int i = 0; i < ND; i++) e.seg0[7*i +: 7] = digit_glyph(i, 1, k);
            e.ss0  = 7'h7F;
            e.sa0  = 4'hF;
            e.seg1 = 28'hFFFFFFF;
            e.ss1  = p == 0 ? 7'h7F : digit_glyph(idx, 1, k);
            e.sa1  = p == 0 ? 4'hF : ~(4'b0001 << idx);
            e.seg2 = 28'h0;
            e.ss2  = p == 0 ? 7'h00 : digit_glyph(idx, 0, k);
            e.sa2  = p == 0 ? 4'h0 : (4'b0001 << idx);
            q.push_back(e);
            if (load) begin
                m_val = value; m_en = digit_en; m_bm = blink_mask; m_lzb = lzb_en;
            end
        end
    end
    task automatic chk(string name, logic [27:0] got, logic [27:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask
    initial forever begin
        @(negedge clk);
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("u0.seg_out", so0, e.seg0);
            chk("u0.scan_seg", 28'(ss0), 28'(e.ss0));
            chk("u0.scan_an", 28'(sa0), 28'(e.sa0));
            chk("u1.seg_out", so1, e.seg1);
            chk("u1.scan_seg", 28'(ss1), 28'(e.ss1));
            chk("u1.scan_an", 28'(sa1), 28'(e.sa1));
            chk("u2.seg_out", so2, e.seg2);
            chk("u2.scan_seg", 28'(ss2), 28'(e.ss2));
            chk("u2.scan_an", 28'(sa2), 28'(e.sa2));
        end
    end
    task automatic drive(bit r, bit ld, logic [15:0] v, logic [3:0] en, logic [3:0] bm, bit lz, int n);
        @(negedge clk);
        rst = r; load = ld; value = v; digit_en = en; blink_mask = bm; lzb_en = lz;
        repeat (n - 1) begin
            @(negedge clk);
            load = 1'b0;
        end
    endtask
    initial begin
        drive(1, 0, 16'h0000, 4'h0, 4'h0, 0, 3);
        drive(0, 1, 16'h12AF, 4'hF, 4'h0, 0, 8);
        drive(0, 1, 16'h12AF, 4'b1011, 4'h0, 0, 6);
        drive(0, 1, 16'h0050, 4'hF, 4'h0, 1, 6);
        drive(0, 1, 16'h0000, 4'hF, 4'h0, 1, 6);
        drive(0, 1, 16'h0300, 4'hF, 4'h0, 1, 6);
        drive(1, 0, 16'h0000, 4'h0, 4'h0, 0, 1);
        drive(0, 1, 16'h12AF, 4'hF, 4'b0001, 0, 24);
        drive(0, 1, 16'h4321, 4'hF, 4'h0, 0, 30);
        drive(0, 0, 16'h4321, 4'hF, 4'h0, 0, 4);
        drive(1, 0, 16'h4321, 4'hF, 4'h0, 0, 1);
        drive(0, 0, 16'h4321, 4'hF, 4'h0, 0, 20);
        repeat (800) begin
            drive($urandom_range(0, 60) == 0, $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom),
                  4'($urandom), 4'($urandom), 1'($urandom), 1);
        end
        drive(0, 0, 16'h0000, 4'h0, 4'h0, 0, 4);
        n_cmp++;
        if (q.size() > 1) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected at most 1", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seven_seg_display_ctrl.md
Name: seven_seg_display_ctrl

Overview:
Parametrised N-digit hex display controller for the board's seven-segment banks. It replaces the purely combinational per-digit decoder with:
- registered, load-strobed shadow data;
- per-digit enable, per-digit blink and leading-zero blanking;
- a selectable time-multiplexed scan mode for boards with a shared segment bus.
It sits between the CSR/debug logic and the HEX pins.

Parameters:
NUM_DIGITS, 6, digit count (1..8)
BLINK_DIV, 25_000_000, clk cycles per blink half-period (>=2)
SCAN_DIV, 50_000, clk cycles per scan slot (>=2)
MUX_MODE, 0, 0 = static per-digit outputs; 1 = scanned shared bus
ACTIVE_LOW, 1, 1 = segment/anode "on" is logic 0

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
load  in  1  capture strobe for value/digit_en/blink_mask/lzb_en
value  in  4*NUM_DIGITS  nibble i = digit i (digit 0 = least significant)
digit_en  in  NUM_DIGITS  per-digit display enable
blink_mask  in  NUM_DIGITS  per-digit blink enable
lzb_en  in  1  leading-zero blanking enable
seg_out  out  7*NUM_DIGITS  static segments, digit i at [7i+6:7i]; bit0 = a .. bit6 = g
scan_seg  out  7  scanned segment bus (MUX_MODE=1)
scan_an  out  NUM_DIGITS  scanned one-hot digit select (MUX_MODE=1)

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst; it takes effect at the next clk edge, including mid-scan or mid-blink.
- BLANK = 7'h7F if ACTIVE_LOW else 7'h00. AN_OFF = all 1s if ACTIVE_LOW else all 0s.
- Reset values:
  - shadow value/digit_en/blink_mask/lzb_en = 0
  - blink counter = 0, blink_phase = 0 (visible)
  - scan counter = 0, scan_idx = 0
  - every seg_out digit = BLANK; scan_seg = BLANK; scan_an = AN_OFF
- Load: load=1 at edge t updates all four shadow registers. Outputs reflect the new data after edge t+1, giving 2-edge latency; all outputs are registered. With load=0 the shadow holds indefinitely.
- Glyph decode: standard hex table, active-high '0' = 7'h3F ... 'F' = 7'h71. Inverted when ACTIVE_LOW, so '0' = 7'h40 and 'F' = 7'h0E.
- Digit i is BLANK if any of the following holds:
  - digit_en[i] = 0;
  - blink_mask[i] = 1 and blink_phase = 1;
  - lzb_en = 1, i > 0, and nibbles i..NUM_DIGITS-1 are all zero.
- Digit 0 is never blanked by LZB, so 0 displays as "0".
- Blink counter runs freely over 0..BLINK_DIV-1. On wrap it toggles blink_phase. load does not reset it. A load coincident with a wrap applies both.
- MUX_MODE=0:
  - seg_out is driven per digit.
  - scan_seg = BLANK and scan_an = AN_OFF constantly.
  - Scan counter may be optimised away.
- MUX_MODE=1:
  - seg_out = all BLANK.
  - Scan counter runs over 0..SCAN_DIV-1. On wrap, scan_idx increments modulo NUM_DIGITS (NUM_DIGITS-1 -> 0).
  - Anti-ghost: in the first cycle of each slot (scan counter = 0), scan_an = AN_OFF and scan_seg = BLANK.
  - For the remaining SCAN_DIV-1 cycles of the slot, scan_an has only bit scan_idx active, and scan_seg = the decoded/blanked glyph of digit scan_idx.
  - A blanked digit still gets its slot, with scan_an active and scan_seg = BLANK.
- NUM_DIGITS = 1: scan_idx stays 0; dead cycle still applies.
- Out-of-range parameters: elaboration-time $error.

Decomposition:
- Package seven_seg_pkg:
  - SEG_W = 7;
  - function hex_to_seg (4-bit nibble -> active-high 7-bit glyph);
  - constant glyph table;
  - function seg_polarity(seg, active_low).
- Sub-module seg_tick_div:
  - parameter DIV;
  - ports clk, rst, tick, cnt_is_zero;
  - free-running counter with a wrap pulse;
  - instantiated twice: blink and scan.
- Everything else (shadow regs, LZB prefix-OR, blank logic, scan mux, output regs) lives in the top module.

Test Plan:
All cases use NUM_DIGITS=4, BLINK_DIV=4, SCAN_DIV=3, ACTIVE_LOW=1 unless stated.
1. Reset -> every seg_out digit = 7'h7F, scan_an = 4'hF, scan_seg = 7'h7F. Assert rst mid-run -> same values after the next edge.
2. load with value = 16'h12AF, digit_en = 4'hF, MUX_MODE=0 -> after 2 edges, digits 0..3 = 7'h0E, 7'h08, 7'h24, 7'h79. digit_en = 4'b1011 -> digit2 = 7'h7F.
3. LZB, lzb_en = 1:
   - value = 16'h0050 -> digit3 = digit2 = 7'h7F, digit1 = 7'h12, digit0 = 7'h40.
   - value = 16'h0000 -> only digit0 = 7'h40.
   - value = 16'h0300 -> digit3 blank, digit1 = 7'h40 shown.
4. Blink, blink_mask = 4'b0001 -> digit0 alternates 4 cycles glyph / 4 cycles 7'h7F from reset; digits 1..3 steady. A load on a wrap edge still lands and the phase still toggles.
5. MUX_MODE=1, value = 16'h4321 -> each 3-cycle slot shows scan_an = 4'hF for 1 cycle, then 2 cycles of the active pattern:
   - 1110 with scan_seg 7'h79
   - 1101 with 7'h24
   - 1011 with 7'h30
   - 0111 with 7'h19
   - wrap back to 1110
   - seg_out stays all 7'h7F throughout.
6. MUX_MODE=1, ACTIVE_LOW=0, assert rst during slot 2 -> next edge scan_an = 4'h0, scan_seg = 7'h00, and scan restarts at idx 0 after rst deasserts.
